hazard_controller: RTL and testbench

Pipeline hazard and stall sequencer for the 5-stage MIPS core. It decides each cycle whether the PC, IF/ID and ID/EX registers advance, stall, bubble or flush, and it schedules the multi-cycle multiply/divide unit. It also exports a registered stall state and a stall-cycle counter for debug.

---
 rtl/hazard_controller.sv | 71 +++++++
 tb/tb_hazard_controller.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/hazard_controller.sv
// hazard_controller: stall/flush sequencer for the 5-stage pipeline.
// It also schedules the mul/div unit and keeps a debug stall state and counter.
module hazard_controller #(
    parameter int MD_LATENCY = 8,
    parameter int CNT_W      = 32
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic [4:0]       ID_Rs,
    input  logic [4:0]       ID_Rt,
    input  logic             ID_UsesRs,
    input  logic             ID_UsesRt,
    input  logic             ID_isBranch,
    input  logic             ID_isMulDiv,
    input  logic             ID_ReadsHiLo,
    input  logic             ID_TakeBranch,
    input  logic [4:0]       EX_WriteReg,
    input  logic             EX_RegWrite,
    input  logic             EX_MemRead,
    input  logic             Freeze,
    output logic             PCWrite,
    output logic             IF_ID_Write,
    output logic             IF_ID_Flush,
    output logic             ID_EX_Write,
    output logic             ID_EX_Flush,
    output logic             MD_Start,
    output logic             MD_Busy,
    output logic [1:0]       State,
    output logic [CNT_W-1:0] StallCount
);
    typedef enum logic [1:0] {RUN, HAZ, MDWAIT, FROZEN} state_t;

    state_t           state_q;
    logic [3:0]       md_cnt_q, md_cnt_d;
    logic [CNT_W-1:0] cnt_q;
    logic             rs_hit, rt_hit, load_use, br_ex, md_haz, stall, fe_en, go;

    assign rs_hit   = (ID_Rs != 5'd0) && (ID_Rs == EX_WriteReg);
    assign rt_hit   = (ID_Rt != 5'd0) && (ID_Rt == EX_WriteReg);
    assign load_use = EX_MemRead & EX_RegWrite & ((ID_UsesRs & rs_hit) | (ID_UsesRt & rt_hit));
    assign br_ex    = ID_isBranch & EX_RegWrite & (rs_hit | rt_hit);
    assign md_haz   = (ID_isMulDiv | ID_ReadsHiLo) & MD_Busy;
    assign stall    = load_use | br_ex | md_haz;

    // Reset and Freeze both hold the front end; only a stall injects a bubble.
    assign fe_en       = Reset_n & ~Freeze;
    assign go          = fe_en & ~stall;
    assign PCWrite     = go;
    assign IF_ID_Write = go;
    assign IF_ID_Flush = go & ID_TakeBranch;
    assign ID_EX_Write = fe_en;
    assign ID_EX_Flush = fe_en & stall;
    assign MD_Start    = go & ID_isMulDiv;
    assign MD_Busy     = md_cnt_q != 4'd0;
    assign md_cnt_d    = MD_Start ? 4'(MD_LATENCY) : md_cnt_q - {3'd0, MD_Busy};
    assign State       = state_q;
    assign StallCount  = cnt_q;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            md_cnt_q <= 4'd0;
            state_q  <= RUN;
            cnt_q    <= '0;
        end else begin
            md_cnt_q <= md_cnt_d;
            state_q  <= Freeze ? FROZEN : md_haz ? MDWAIT : (load_use | br_ex) ? HAZ : RUN;
            if (!PCWrite && cnt_q != '1)
                cnt_q <= cnt_q + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_hazard_controller.sv
// tb_hazard_controller: directed scenarios plus random traffic, checked every
// cycle against a behavioural model of the hazard rules.
module tb_hazard_controller;
    logic        Clk = 1'b0, Reset_n = 1'b0;
    logic [4:0]  ID_Rs, ID_Rt, EX_WriteReg;
    logic        ID_UsesRs, ID_UsesRt, ID_isBranch, ID_isMulDiv, ID_ReadsHiLo, ID_TakeBranch;
    logic        EX_RegWrite, EX_MemRead, Freeze;
    logic        PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Write, ID_EX_Flush, MD_Start, MD_Busy;
    logic [1:0]  State;
    logic [31:0] StallCount;

    int nerr = 0, nchk = 0;
    int m_busy, m_state;
    logic [31:0] m_cnt;
    logic e_pc, e_start, e_lu, e_br, e_md;

    hazard_controller #(.MD_LATENCY(8), .CNT_W(32)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt),
        .ID_UsesRs(ID_UsesRs), .ID_UsesRt(ID_UsesRt), .ID_isBranch(ID_isBranch),
        .ID_isMulDiv(ID_isMulDiv), .ID_ReadsHiLo(ID_ReadsHiLo), .ID_TakeBranch(ID_TakeBranch),
        .EX_WriteReg(EX_WriteReg), .EX_RegWrite(EX_RegWrite), .EX_MemRead(EX_MemRead),
        .Freeze(Freeze), .PCWrite(PCWrite), .IF_ID_Write(IF_ID_Write), .IF_ID_Flush(IF_ID_Flush),
        .ID_EX_Write(ID_EX_Write), .ID_EX_Flush(ID_EX_Flush), .MD_Start(MD_Start),
        .MD_Busy(MD_Busy), .State(State), .StallCount(StallCount)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic idle();
        ID_Rs = 0; ID_Rt = 0; ID_UsesRs = 0; ID_UsesRt = 0; ID_isBranch = 0;
        ID_isMulDiv = 0; ID_ReadsHiLo = 0; ID_TakeBranch = 0;
        EX_WriteReg = 0; EX_RegWrite = 0; EX_MemRead = 0; Freeze = 0;
    endtask

    task automatic model_check();
        logic hs, ht, st, en, ex;
        hs = ID_Rs != 0 && ID_Rs == EX_WriteReg;
        ht = ID_Rt != 0 && ID_Rt == EX_WriteReg;
        e_lu = EX_MemRead && EX_RegWrite && ((ID_UsesRs && hs) || (ID_UsesRt && ht));
        e_br = ID_isBranch && EX_RegWrite && (hs || ht);
        e_md = (ID_isMulDiv || ID_ReadsHiLo) && m_busy > 0;
        st = e_lu || e_br || e_md;
        en = !Freeze && !st;
        ex = !Freeze;
        e_pc = en;
        e_start = en && ID_isMulDiv;
        chk("PCWrite", PCWrite, en);
        chk("IF_ID_Write", IF_ID_Write, en);
        chk("IF_ID_Flush", IF_ID_Flush, en && ID_TakeBranch);
        chk("ID_EX_Write", ID_EX_Write, ex);
        chk("ID_EX_Flush", ID_EX_Flush, ex && st);
        chk("MD_Start", MD_Start, e_start);
        chk("MD_Busy", MD_Busy, m_busy > 0);
        chk("State", State, m_state);
        chk("StallCount", StallCount, m_cnt);
    endtask

    task automatic model_update();
        if (e_start) m_busy = 8;
        else if (m_busy > 0) m_busy--;
        m_state = Freeze ? 3 : e_md ? 2 : (e_lu || e_br) ? 1 : 0;
        if (!e_pc && m_cnt != 32'hFFFF_FFFF) m_cnt++;
    endtask

    task automatic cycle();
        @(negedge Clk);
        model_check();
        @(posedge Clk);
        model_update();
        #1;
    endtask

    task automatic model_reset();
        m_busy = 0; m_state = 0; m_cnt = 0;
    endtask

    // Asynchronous reset pulse placed between edges.
    task automatic do_reset();
        Reset_n = 0;
        model_reset();
        #1;
        chk("rst_PCWrite", PCWrite, 0);
        chk("rst_ID_EX_Write", ID_EX_Write, 0);
        chk("rst_MD_Busy", MD_Busy, 0);
        chk("rst_State", State, 0);
        chk("rst_StallCount", StallCount, 0);
        #1 Reset_n = 1;
        idle();
    endtask

    initial begin
        idle();
        model_reset();
        @(posedge Clk);
        #1;
        do_reset();

        // load-use on Rs
        EX_WriteReg = 2; EX_RegWrite = 1; EX_MemRead = 1; ID_Rs = 2; ID_UsesRs = 1;
        #1;
        chk("lu_PCWrite", PCWrite, 0);
        chk("lu_Flush", ID_EX_Flush, 1);
        cycle();
        chk("lu_State", State, 1);
        chk("lu_Count", StallCount, 1);
        EX_RegWrite = 0; EX_MemRead = 0;
        #1 chk("lu_after_PCWrite", PCWrite, 1);
        cycle();

        // branch depending on ALU result in EX
        do_reset();
        EX_WriteReg = 5; EX_RegWrite = 1; ID_isBranch = 1; ID_Rs = 5; ID_UsesRs = 1; ID_TakeBranch = 1;
        #1;
        chk("br_PCWrite", PCWrite, 0);
        chk("br_IFFlush", IF_ID_Flush, 0);
        cycle();
        EX_RegWrite = 0;
        #1;
        chk("br2_IFFlush", IF_ID_Flush, 1);
        chk("br2_PCWrite", PCWrite, 1);
        cycle();

        // mult then mfhi
        do_reset();
        ID_isMulDiv = 1;
        #1 chk("md_Start", MD_Start, 1);
        cycle();
        chk("md_Busy", MD_Busy, 1);
        ID_isMulDiv = 0; ID_ReadsHiLo = 1;
        cycle();
        chk("md_State", State, 2);
        repeat (7) cycle();
        chk("md_Count", StallCount, 8);
        #1 chk("md_advance", PCWrite, 1);
        cycle();

        // $0 and unused operand never stall
        do_reset();
        EX_WriteReg = 0; EX_RegWrite = 1; EX_MemRead = 1; ID_UsesRs = 1; ID_UsesRt = 1;
        #1 chk("r0_PCWrite", PCWrite, 1);
        cycle();
        EX_WriteReg = 3; ID_Rt = 3; ID_UsesRt = 0; ID_Rs = 1;
        #1 chk("unused_PCWrite", PCWrite, 1);
        cycle();

        // Freeze during load-use, mul/div counter still draining
        do_reset();
        ID_isMulDiv = 1;
        cycle();
        ID_isMulDiv = 0;
        EX_WriteReg = 2; EX_RegWrite = 1; EX_MemRead = 1; ID_Rs = 2; ID_UsesRs = 1; Freeze = 1;
        #1 chk("fz_Flush", ID_EX_Flush, 0);
        repeat (3) cycle();
        chk("fz_State", State, 3);
        chk("fz_Count", StallCount, 3);
        Freeze = 0;
        #1 chk("fz_rel_Flush", ID_EX_Flush, 1);
        cycle();
        chk("fz_Count2", StallCount, 4);
        chk("fz_Busy", MD_Busy, 1);
        // reset mid mul/div with a busy count in flight
        idle();
        do_reset();

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            ID_Rs = 5'($urandom_range(0, 3));
            ID_Rt = 5'($urandom_range(0, 3));
            EX_WriteReg = 5'($urandom_range(0, 3));
            ID_UsesRs = 1'($urandom);
            ID_UsesRt = 1'($urandom);
            ID_isBranch = $urandom_range(0, 3) == 0;
            ID_isMulDiv = $urandom_range(0, 5) == 0;
            ID_ReadsHiLo = $urandom_range(0, 5) == 0;
            ID_TakeBranch = 1'($urandom);
            EX_RegWrite = 1'($urandom);
            EX_MemRead = 1'($urandom);
            Freeze = $urandom_range(0, 9) == 0;
            cycle();
            if ($urandom_range(0, 499) == 0) do_reset();
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
